// File: rtl/inst_fetch_ctrl_if.sv
// Fetch-side bus bundle: sram-like instruction request port plus the
// one-entry valid/ready buffer that feeds decode.
interface inst_fetch_ctrl_if;
  logic        inst_req;
  logic        inst_wr;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;

  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        if_adel;

  modport master (
    output inst_req, inst_wr, inst_size, inst_addr,
    input  inst_addr_ok, inst_data_ok, inst_rdata,
    output if_valid, if_pc, if_inst, if_adel,
    input  if_ready
  );

  modport slave (
    input  inst_req, inst_wr, inst_size, inst_addr,
    output inst_addr_ok, inst_data_ok, inst_rdata,
    input  if_valid, if_pc, if_inst, if_adel,
    output if_ready
  );
endinterface

// File: rtl/inst_fetch_ctrl.sv
// Instruction fetch controller: owns the next PC, applies delay-slot, eret and
// exception redirects, keeps one sram-like request in flight, buffers one instruction.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'hBFC0_0000,
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic [1:0]          pc_src,
  input  logic                redirect_en,
  input  logic [31:0]         branch_target,
  input  logic [31:0]         epc,
  input  logic [31:0]         dec_pcplus4,
  inst_fetch_ctrl_if.master   bus
);

  typedef enum logic [1:0] {S_RST, S_REQ, S_WAIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] issued_pc_q, issued_pc_d;
  logic [31:0] target_q, target_d;
  logic        discard_q, discard_d;
  logic        ds_pend_q, ds_pend_d;
  logic        buf_valid_q, buf_valid_d;
  logic [31:0] buf_pc_q, buf_pc_d;
  logic [31:0] buf_inst_q, buf_inst_d;
  logic        buf_adel_q, buf_adel_d;

  logic can_issue, aligned, req, hs, data_ret;
  logic take_exc, take_eret, take_br, flush;

  always_comb begin
    can_issue = !buf_valid_q || bus.if_ready;
    aligned   = (fetch_pc_q[1:0] == 2'b00);
    req       = (state_q == S_REQ) && can_issue && aligned;
    hs        = req && bus.inst_addr_ok;
    data_ret  = (state_q == S_WAIT) && bus.inst_data_ok;
    take_exc  = (pc_src == 2'd3);
    take_eret = redirect_en && (pc_src == 2'd2);
    take_br   = redirect_en && (pc_src == 2'd1);
    flush     = take_exc || take_eret;
  end

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    target_d    = target_q;
    discard_d   = discard_q;
    ds_pend_d   = ds_pend_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    buf_adel_d  = buf_adel_q;

    case (state_q)
      S_RST:   state_d = S_REQ;
      S_REQ:   if (hs) state_d = S_WAIT;
      S_WAIT:  if (data_ret) state_d = S_REQ;
      default: state_d = S_RST;
    endcase

    // A pending delay slot redirects to the saved target as soon as the slot is accepted.
    if (hs) begin
      issued_pc_d = fetch_pc_q;
      if (ds_pend_q) begin
        fetch_pc_d = target_q;
        ds_pend_d  = 1'b0;
      end else begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
    end

    if (buf_valid_q && bus.if_ready) buf_valid_d = 1'b0;

    if (data_ret) begin
      if (discard_q) begin
        discard_d = 1'b0;
      end else begin
        buf_valid_d = 1'b1;
        buf_pc_d    = issued_pc_q;
        buf_inst_d  = bus.inst_rdata;
        buf_adel_d  = 1'b0;
      end
    end

    if ((state_q == S_REQ) && can_issue && !aligned) begin
      buf_valid_d = 1'b1;
      buf_pc_d    = fetch_pc_q;
      buf_inst_d  = 32'd0;
      buf_adel_d  = 1'b1;
    end

    if (flush) begin
      buf_valid_d = 1'b0;
      ds_pend_d   = 1'b0;
      fetch_pc_d  = take_exc ? EXC_VECTOR : epc;
      // Whatever is (or just became) outstanding belongs to the flushed stream.
      discard_d   = hs || ((state_q == S_WAIT) && !bus.inst_data_ok);
    end else if (take_br) begin
      if (fetch_pc_q == dec_pcplus4) begin
        if (hs) begin
          fetch_pc_d = branch_target;
        end else begin
          ds_pend_d = 1'b1;
          target_d  = branch_target;
        end
      end else begin
        fetch_pc_d = branch_target;
        if (hs) discard_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= S_RST;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= 32'd0;
      target_q    <= 32'd0;
      discard_q   <= 1'b0;
      ds_pend_q   <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= 32'd0;
      buf_inst_q  <= 32'd0;
      buf_adel_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      target_q    <= target_d;
      discard_q   <= discard_d;
      ds_pend_q   <= ds_pend_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
      buf_adel_q  <= buf_adel_d;
    end
  end

  assign bus.inst_req  = req;
  assign bus.inst_wr   = 1'b0;
  assign bus.inst_size = 2'b10;
  assign bus.inst_addr = fetch_pc_q;
  assign bus.if_valid  = buf_valid_q;
  assign bus.if_pc     = buf_pc_q;
  assign bus.if_inst   = buf_inst_q;
  assign bus.if_adel   = buf_adel_q;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: sram-like memory model with programmable
// data latency, request/delivery logs, and hand-computed expectations.
module tb_inst_fetch_ctrl;
  logic        clk = 1'b0;
  logic        resetn;
  logic [1:0]  pc_src;
  logic        redirect_en;
  logic [31:0] branch_target, epc, dec_pcplus4;

  inst_fetch_ctrl_if bus();

  inst_fetch_ctrl dut (
    .clk(clk), .resetn(resetn), .pc_src(pc_src), .redirect_en(redirect_en),
    .branch_target(branch_target), .epc(epc), .dec_pcplus4(dec_pcplus4), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] memw(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  // Memory model: immediate addr_ok (gated), data_ok after lat extra cycles.
  logic        addr_gate;
  int          lat;
  logic        pend;
  int          cnt;
  logic [31:0] pend_addr;

  assign bus.inst_addr_ok = bus.inst_req && addr_gate;
  assign bus.inst_data_ok = pend && (cnt == 0);
  assign bus.inst_rdata   = memw(pend_addr);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend <= 1'b0;
      cnt  <= 0;
    end else if (bus.inst_req && bus.inst_addr_ok) begin
      pend      <= 1'b1;
      pend_addr <= bus.inst_addr;
      cnt       <= lat;
    end else if (pend && cnt > 0) begin
      cnt <= cnt - 1;
    end else if (pend) begin
      pend <= 1'b0;
    end
  end

  logic [31:0] rq[$];
  logic [31:0] dq[$];
  logic [31:0] dq_inst[$];

  always @(negedge clk) begin
    if (resetn && bus.inst_req && bus.inst_addr_ok) begin
      rq.push_back(bus.inst_addr);
      $display("REQ     addr=%h", bus.inst_addr);
    end
    if (resetn && bus.if_valid && bus.if_ready) begin
      dq.push_back(bus.if_pc);
      dq_inst.push_back(bus.if_inst);
      $display("DELIVER pc=%h inst=%h adel=%b", bus.if_pc, bus.if_inst, bus.if_adel);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    rq.delete();
    dq.delete();
    dq_inst.delete();
  endtask

  // kind 0: if_valid; 1: if_valid && if_pc==a; 2: inst_req && inst_addr==a
  task automatic wait_cond(input int kind, input logic [31:0] a, input string tag);
    bit hit;
    for (int i = 0; i < 40; i++) begin
      case (kind)
        0:       hit = bus.if_valid;
        1:       hit = bus.if_valid && (bus.if_pc == a);
        default: hit = bus.inst_req && (bus.inst_addr == a);
      endcase
      if (hit) return;
      step();
    end
    checks++;
    errors++;
    $display("FAIL %s timeout waiting for event", tag);
  endtask

  task automatic redirect(input logic [1:0] src, input logic [31:0] tgt, input logic [31:0] pcp4);
    pc_src        = src;
    redirect_en   = 1'b1;
    branch_target = tgt;
    epc           = tgt;
    dec_pcplus4   = pcp4;
    step();
    pc_src      = 2'd0;
    redirect_en = 1'b0;
  endtask

  initial begin
    bit found;
    resetn        = 1'b0;
    pc_src        = 2'd0;
    redirect_en   = 1'b0;
    branch_target = 32'd0;
    epc           = 32'd0;
    dec_pcplus4   = 32'd0;
    bus.if_ready  = 1'b1;
    addr_gate     = 1'b1;
    lat           = 0;
    repeat (3) step();

    // Reset values
    check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
    check("rst_if_pc",    bus.if_pc,   32'd0);
    check("rst_if_inst",  bus.if_inst, 32'd0);
    check("rst_if_adel",  {31'd0, bus.if_adel}, 32'd0);
    check("rst_inst_req", {31'd0, bus.inst_req}, 32'd0);
    check("rst_inst_addr", bus.inst_addr, 32'hBFC0_0000);
    check("inst_wr",      {31'd0, bus.inst_wr}, 32'd0);
    check("inst_size",    {30'd0, bus.inst_size}, 32'd2);

    // Sequential fetch after reset release
    resetn = 1'b1;
    repeat (10) step();
    check("seq_req0", rq[0], 32'hBFC0_0000);
    check("seq_req1", rq[1], 32'hBFC0_0004);
    check("seq_req2", rq[2], 32'hBFC0_0008);
    check("seq_pc0",  dq[0], 32'hBFC0_0000);
    check("seq_pc1",  dq[1], 32'hBFC0_0004);
    check("seq_inst0", dq_inst[0], memw(32'hBFC0_0000));

    // Branch at 0x100 with delay slot 0x104 already buffered
    bus.if_ready = 1'b0;
    redirect(2'd2, 32'h0000_0100, 32'd0);
    wait_cond(1, 32'h0000_0100, "brA_wait100");
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    wait_cond(1, 32'h0000_0104, "brA_wait104");
    clear_logs();
    bus.if_ready = 1'b1;
    redirect(2'd1, 32'h0000_0200, 32'h0000_0104);
    repeat (10) step();
    check("brA_pc0", dq[0], 32'h0000_0104);
    check("brA_pc1", dq[1], 32'h0000_0200);
    check("brA_inst1", dq_inst[1], memw(32'h0000_0200));
    check("brA_req200", rq[1], 32'h0000_0200);
    found = 0;
    foreach (dq[i]) if (dq[i] == 32'h0000_0108) found = 1;
    check("brA_no108", {31'd0, found}, 32'd0);

    // Same branch, delay slot not yet requested
    bus.if_ready = 1'b0;
    redirect(2'd2, 32'h0000_0100, 32'd0);
    wait_cond(1, 32'h0000_0100, "brB_wait100");
    addr_gate    = 1'b0;
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    clear_logs();
    redirect(2'd1, 32'h0000_0200, 32'h0000_0104);
    check("brB_addr_hold", bus.inst_addr, 32'h0000_0104);
    addr_gate    = 1'b1;
    bus.if_ready = 1'b1;
    repeat (10) step();
    check("brB_req0", rq[0], 32'h0000_0104);
    check("brB_req1", rq[1], 32'h0000_0200);
    check("brB_pc0",  dq[0], 32'h0000_0104);
    check("brB_pc1",  dq[1], 32'h0000_0200);

    // Exception while waiting on 0x300
    lat = 3;
    redirect(2'd2, 32'h0000_0300, 32'd0);
    wait_cond(2, 32'h0000_0300, "exc_wait300");
    step();
    clear_logs();
    pc_src = 2'd3;
    step();
    pc_src = 2'd0;
    lat    = 0;
    check("exc_valid0", {31'd0, bus.if_valid}, 32'd0);
    wait_cond(0, 32'd0, "exc_waitvalid");
    check("exc_pc",   bus.if_pc, 32'hBFC0_0380);
    check("exc_inst", bus.if_inst, memw(32'hBFC0_0380));
    check("exc_req0", rq[0], 32'hBFC0_0380);
    check("exc_ndeliv", dq.size(), 32'd0);

    // jr to misaligned 0x00400002; slot 0xBFC00380 is in the buffer
    bus.if_ready = 1'b0;
    check("jr_slot_pc", bus.if_pc, 32'hBFC0_0380);
    clear_logs();
    bus.if_ready = 1'b1;
    redirect(2'd1, 32'h0040_0002, 32'hBFC0_0380);
    bus.if_ready = 1'b0;
    wait_cond(0, 32'd0, "jr_waitvalid");
    check("jr_pc",   bus.if_pc, 32'h0040_0002);
    check("jr_adel", {31'd0, bus.if_adel}, 32'd1);
    check("jr_inst", bus.if_inst, 32'd0);
    check("jr_slot_deliv", dq[0], 32'hBFC0_0380);
    check("jr_nreq", rq.size(), 32'd1);
    bus.if_ready = 1'b1;
    @(negedge clk);
    check("jr_no_req", {31'd0, bus.inst_req}, 32'd0);
    step();

    // Decode stalls 5 cycles with a full buffer
    bus.if_ready = 1'b0;
    pc_src = 2'd3;
    step();
    pc_src = 2'd0;
    wait_cond(1, 32'hBFC0_0380, "stall_wait");
    clear_logs();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_req",  {31'd0, bus.inst_req}, 32'd0);
      check("stall_pc",   bus.if_pc, 32'hBFC0_0380);
      check("stall_inst", bus.if_inst, memw(32'hBFC0_0380));
      step();
    end
    bus.if_ready = 1'b1;
    step();
    bus.if_ready = 1'b0;
    repeat (6) step();
    check("stall_nreq", rq.size(), 32'd1);
    check("stall_req0", rq[0], 32'hBFC0_0384);
    check("stall_deliv", dq[0], 32'hBFC0_0380);
    check("stall_buf", bus.if_pc, 32'hBFC0_0384);

    // Asynchronous reset in the middle of a transaction
    bus.if_ready = 1'b1;
    repeat (3) step();
    resetn = 1'b0;
    #1;
    check("arst_valid", {31'd0, bus.if_valid}, 32'd0);
    check("arst_req",   {31'd0, bus.inst_req}, 32'd0);
    check("arst_addr",  bus.inst_addr, 32'hBFC0_0000);
    step();
    step();
    resetn = 1'b1;
    clear_logs();
    repeat (6) step();
    check("arst_req0", rq[0], 32'hBFC0_0000);
    check("arst_pc0",  dq[0], 32'hBFC0_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout bench did not complete");
    $fatal(1);
  end
endmodule
